vending_admin: RTL and testbench

- Operator-side counterpart of the customer purchase path: money and stock flow in the other direction.
- Purchases drain supply and fill the cash box. This block refills supply (restock) and empties the cash box (withdrawal).
- Access is gated by PIN authentication with failure lockout and an idle session timeout.
- Active only while the machine is in admin mode (mode=0). Outputs feed the same supply/money registers the customer path writes.

---
 rtl/vending_pkg.sv | 21 ++
 rtl/vending_auth.sv | 60 ++++++
 rtl/vending_admin.sv | 168 ++++++++++++++++
 tb/tb_vending_admin.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types for the operator-side vending admin block.
package vending_pkg;

    localparam int DEF_SUPPLY_W = 4;
    localparam int DEF_MONEY_W  = 11;

    typedef enum logic [1:0] {
        OP_RESTOCK      = 2'b00,
        OP_WITHDRAW     = 2'b01,
        OP_WITHDRAW_ALL = 2'b10,
        OP_LOGOUT       = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SESSION = 2'b01,
        ST_RESP    = 2'b10,
        ST_LOCKED  = 2'b11
    } state_e;

endpackage

// File: rtl/vending_auth.sv
// PIN check, consecutive-failure counter and lockout timer.
module vending_auth #(
    parameter logic [3:0] ADMIN_PIN   = 4'hA,
    parameter int         MAX_FAILS   = 3,
    parameter int         LOCK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       pin_valid_i,
    input  logic [3:0] pin_i,
    output logic       auth_ok_o,
    output logic       auth_fail_o,
    output logic       lock_trip_o,
    output logic       lock_done_o,
    output logic       locked_o
);

    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    logic [FW-1:0] fail_cnt_q;
    logic [LW-1:0] lock_cnt_q;
    logic          locked_q;
    logic          attempt;

    // An attempt only counts while the session FSM is idle in admin mode.
    always_comb begin
        attempt     = en_i & pin_valid_i & ~locked_q;
        auth_ok_o   = attempt & (pin_i == ADMIN_PIN);
        auth_fail_o = attempt & (pin_i != ADMIN_PIN);
        lock_trip_o = auth_fail_o & (fail_cnt_q == FW'(MAX_FAILS - 1));
        lock_done_o = locked_q & (lock_cnt_q == LW'(LOCK_CYCLES - 1));
        locked_o    = locked_q;
    end

    // Failure counting and lockout countdown; lockout is independent of mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_cnt_q <= '0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else if (lock_done_o) begin
            locked_q   <= 1'b0;
            fail_cnt_q <= '0;
            lock_cnt_q <= '0;
        end else if (locked_q) begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
        end else if (lock_trip_o) begin
            locked_q   <= 1'b1;
            lock_cnt_q <= '0;
            fail_cnt_q <= FW'(MAX_FAILS);
        end else if (auth_fail_o) begin
            fail_cnt_q <= fail_cnt_q + 1'b1;
        end else if (auth_ok_o) begin
            fail_cnt_q <= '0;
        end
    end

endmodule

// File: rtl/vending_admin.sv
// Operator session controller: restock supply and withdraw cash behind a PIN.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | logged out, waiting for a PIN in admin mode
// ST_SESSION | logged in, req_ready high, idle timer running
// ST_RESP    | one cycle after an accepted request, done/redlight out
// ST_LOCKED  | too many wrong PINs, PIN entry ignored until timer ends
module vending_admin
    import vending_pkg::*;
#(
    parameter int         SUPPLY_W    = DEF_SUPPLY_W,
    parameter int         MONEY_W     = DEF_MONEY_W,
    parameter logic [3:0] ADMIN_PIN   = 4'hA,
    parameter int         MAX_SUPPLY  = 15,
    parameter int         MAX_FAILS   = 3,
    parameter int         LOCK_CYCLES = 16,
    parameter int         TIMEOUT     = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic                pin_valid,
    input  logic [3:0]          pin,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          op,
    input  logic [SUPPLY_W-1:0] qty,
    input  logic [MONEY_W-1:0]  cash_amt,
    input  logic [SUPPLY_W-1:0] machine_supply,
    input  logic [MONEY_W-1:0]  machine_money,
    output logic [SUPPLY_W-1:0] new_supply,
    output logic [MONEY_W-1:0]  new_machine_money,
    output logic [MONEY_W-1:0]  cash_out,
    output logic                done,
    output logic                redlight,
    output logic                locked
);

    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e              state_q;
    logic [IW-1:0]       idle_cnt_q;
    logic                req_ready_q, done_q, redlight_q;
    logic [SUPPLY_W-1:0] new_supply_q;
    logic [MONEY_W-1:0]  new_money_q, cash_out_q;

    logic auth_ok, auth_fail, lock_trip, lock_done;

    logic [SUPPLY_W:0]   restock_sum;
    logic                restock_fits, withdraw_fits;
    logic [SUPPLY_W-1:0] supply_d;
    logic [MONEY_W-1:0]  money_d, cash_d;
    logic                err_d;

    vending_auth #(
        .ADMIN_PIN   (ADMIN_PIN),
        .MAX_FAILS   (MAX_FAILS),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_auth (
        .clk         (clk),
        .rst         (rst),
        .en_i        ((state_q == ST_IDLE) & ~mode),
        .pin_valid_i (pin_valid),
        .pin_i       (pin),
        .auth_ok_o   (auth_ok),
        .auth_fail_o (auth_fail),
        .lock_trip_o (lock_trip),
        .lock_done_o (lock_done),
        .locked_o    (locked)
    );

    // Request results; sums are one bit wider so neither balance can wrap.
    always_comb begin
        restock_sum   = {1'b0, machine_supply} + {1'b0, qty};
        restock_fits  = restock_sum <= (SUPPLY_W + 1)'(MAX_SUPPLY);
        withdraw_fits = cash_amt <= machine_money;
        supply_d      = machine_supply;
        money_d       = machine_money;
        cash_d        = '0;
        err_d         = 1'b0;
        case (op_e'(op))
            OP_RESTOCK: begin
                if (restock_fits) supply_d = restock_sum[SUPPLY_W-1:0];
                else              err_d    = 1'b1;
            end
            OP_WITHDRAW: begin
                if (withdraw_fits) begin
                    money_d = machine_money - cash_amt;
                    cash_d  = cash_amt;
                end else begin
                    err_d = 1'b1;
                end
            end
            OP_WITHDRAW_ALL: begin
                money_d = '0;
                cash_d  = machine_money;
            end
            default: ;
        endcase
    end

    // Session FSM with registered outputs; result registers hold between requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idle_cnt_q   <= '0;
            req_ready_q  <= 1'b0;
            done_q       <= 1'b0;
            redlight_q   <= 1'b0;
            new_supply_q <= '0;
            new_money_q  <= '0;
            cash_out_q   <= '0;
        end else begin
            done_q     <= 1'b0;
            redlight_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (auth_ok) begin
                        state_q     <= ST_SESSION;
                        req_ready_q <= 1'b1;
                        idle_cnt_q  <= '0;
                    end else if (auth_fail) begin
                        redlight_q <= 1'b1;
                        if (lock_trip) state_q <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (lock_done) state_q <= ST_IDLE;
                end
                ST_SESSION: begin
                    if (mode) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b0;
                        idle_cnt_q  <= '0;
                    end else if (req_valid && req_ready_q) begin
                        idle_cnt_q   <= '0;
                        req_ready_q  <= 1'b0;
                        done_q       <= 1'b1;
                        redlight_q   <= err_d;
                        new_supply_q <= supply_d;
                        new_money_q  <= money_d;
                        cash_out_q   <= cash_d;
                        state_q      <= (op_e'(op) == OP_LOGOUT) ? ST_IDLE : ST_RESP;
                    end else if (idle_cnt_q == IW'(TIMEOUT - 1)) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b0;
                        idle_cnt_q  <= '0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= mode ? ST_IDLE : ST_SESSION;
                    req_ready_q <= ~mode;
                end
            endcase
        end
    end

    assign req_ready         = req_ready_q;
    assign done              = done_q;
    assign redlight          = redlight_q;
    assign new_supply        = new_supply_q;
    assign new_machine_money = new_money_q;
    assign cash_out          = cash_out_q;

endmodule

// File: tb/tb_vending_admin.sv
// Directed bench for vending_admin with hand-computed expectations.
module tb_vending_admin;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic        pin_valid = 1'b0;
    logic [3:0]  pin = 4'h0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  op = 2'b00;
    logic [3:0]  qty = '0;
    logic [10:0] cash_amt = '0;
    logic [3:0]  machine_supply = '0;
    logic [10:0] machine_money = '0;
    logic [3:0]  new_supply;
    logic [10:0] new_machine_money;
    logic [10:0] cash_out;
    logic        done, redlight, locked;

    int total = 0;
    int bad   = 0;

    vending_admin dut (
        .clk               (clk),
        .rst               (rst),
        .mode              (mode),
        .pin_valid         (pin_valid),
        .pin               (pin),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .op                (op),
        .qty               (qty),
        .cash_amt          (cash_amt),
        .machine_supply    (machine_supply),
        .machine_money     (machine_money),
        .new_supply        (new_supply),
        .new_machine_money (new_machine_money),
        .cash_out          (cash_out),
        .done              (done),
        .redlight          (redlight),
        .locked            (locked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [1:0] o, input logic [3:0] q, input logic [10:0] c,
                           input logic [3:0] s, input logic [10:0] m);
        op = o; qty = q; cash_amt = c; machine_supply = s; machine_money = m;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        #3;
        check("rst_ready", req_ready, 0);
        check("rst_done", done, 0);
        check("rst_cash", cash_out, 0);
        check("rst_locked", locked, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // login
        pin = 4'hA; pin_valid = 1'b1;
        tick();
        pin_valid = 1'b0;
        check("login_ready", req_ready, 1);
        check("login_red", redlight, 0);

        // restock 7+5
        request(2'b00, 4'd5, 11'd0, 4'd7, 11'd0);
        check("rs1_supply", new_supply, 12);
        check("rs1_done", done, 1);
        check("rs1_red", redlight, 0);
        check("rs1_ready_n1", req_ready, 0);
        tick();
        check("rs1_ready_n2", req_ready, 1);
        check("rs1_done_n2", done, 0);

        // restock 12+5 overflows ceiling
        request(2'b00, 4'd5, 11'd0, 4'd12, 11'd0);
        check("rs2_red", redlight, 1);
        check("rs2_supply", new_supply, 12);
        check("rs2_done", done, 1);
        tick();

        // withdraw 200 of 500
        request(2'b01, 4'd0, 11'd200, 4'd1, 11'd500);
        check("wd1_money", new_machine_money, 300);
        check("wd1_cash", cash_out, 200);
        check("wd1_red", redlight, 0);
        check("wd1_supply", new_supply, 1);
        tick();
        check("wd1_hold", cash_out, 200);

        // withdraw 400 of 300
        request(2'b01, 4'd0, 11'd400, 4'd1, 11'd300);
        check("wd2_red", redlight, 1);
        check("wd2_money", new_machine_money, 300);
        check("wd2_cash", cash_out, 0);
        check("wd2_done", done, 1);
        tick();

        // withdraw all 2047
        request(2'b10, 4'd0, 11'd0, 4'd2, 11'd2047);
        check("wa_cash", cash_out, 2047);
        check("wa_money", new_machine_money, 0);
        check("wa_red", redlight, 0);
        tick();

        // zero quantity restock
        request(2'b00, 4'd0, 11'd0, 4'd3, 11'd77);
        check("q0_supply", new_supply, 3);
        check("q0_money", new_machine_money, 77);
        check("q0_cash", cash_out, 0);
        check("q0_done", done, 1);
        check("q0_red", redlight, 0);
        tick();

        // zero cash withdraw
        request(2'b01, 4'd0, 11'd0, 4'd3, 11'd77);
        check("c0_money", new_machine_money, 77);
        check("c0_red", redlight, 0);
        check("c0_done", done, 1);
        tick();

        // restock exactly to ceiling
        request(2'b00, 4'd5, 11'd0, 4'd10, 11'd0);
        check("ceil_supply", new_supply, 15);
        check("ceil_red", redlight, 0);
        tick();

        // restock 15+15 must not wrap
        request(2'b00, 4'd15, 11'd0, 4'd15, 11'd0);
        check("wrap_supply", new_supply, 15);
        check("wrap_red", redlight, 1);
        tick();

        // logout
        request(2'b11, 4'd0, 11'd0, 4'd4, 11'd9);
        check("lo_done", done, 1);
        check("lo_supply", new_supply, 4);
        check("lo_money", new_machine_money, 9);
        check("lo_ready", req_ready, 0);
        tick();
        check("lo_ready2", req_ready, 0);
        check("lo_done2", done, 0);

        // three wrong PINs
        pin = 4'h3; pin_valid = 1'b1;
        tick();
        check("bad1_red", redlight, 1);
        check("bad1_locked", locked, 0);
        tick();
        check("bad2_red", redlight, 1);
        check("bad2_locked", locked, 0);
        tick();
        check("bad3_red", redlight, 1);
        check("bad3_locked", locked, 1);

        // correct PIN during lockout is ignored
        pin = 4'hA;
        tick();
        pin_valid = 1'b0;
        check("lk_ready", req_ready, 0);
        check("lk_red", redlight, 0);
        check("lk_locked", locked, 1);
        mode = 1'b1;
        repeat (13) tick();
        mode = 1'b0;
        tick();
        check("lk_e15", locked, 1);
        tick();
        check("lk_e16", locked, 0);

        // login after lockout
        pin_valid = 1'b1;
        tick();
        pin_valid = 1'b0;
        check("relogin_ready", req_ready, 1);

        // idle timeout
        repeat (63) tick();
        check("to_63", req_ready, 1);
        tick();
        check("to_64", req_ready, 0);
        check("to_done", done, 0);
        check("to_red", redlight, 0);

        // mode abort with simultaneous request
        pin_valid = 1'b1;
        tick();
        pin_valid = 1'b0;
        check("ab_login", req_ready, 1);
        mode = 1'b1;
        op = 2'b01; cash_amt = 11'd5; machine_money = 11'd100; req_valid = 1'b1;
        tick();
        check("ab_done", done, 0);
        check("ab_ready", req_ready, 0);
        check("ab_cash", cash_out, 0);
        mode = 1'b0;
        tick();
        req_valid = 1'b0;
        check("ab_idle_ready", req_ready, 0);
        check("ab_idle_done", done, 0);

        // async reset mid-response
        pin_valid = 1'b1;
        tick();
        pin_valid = 1'b0;
        request(2'b01, 4'd0, 11'd30, 4'd0, 11'd100);
        check("pre_rst_cash", cash_out, 30);
        check("pre_rst_done", done, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_done", done, 0);
        check("arst_cash", cash_out, 0);
        check("arst_money", new_machine_money, 0);
        check("arst_ready", req_ready, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_ready", req_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
